reg_bank_alu: RTL and testbench



---
 rtl/reg_bank_alu.sv | 100 ++++++++++
 tb/tb_reg_bank_alu.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/reg_bank_alu.sv
// Register-transfer datapath: 16-entry address space with R0-R9, operand/output registers and a
// combinational 16-bit ALU whose operands and result are mapped into that space.
module reg_bank_alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  from_addr_i,
  input  logic [3:0]  to_addr_i,
  input  logic        enable_i,
  input  logic [15:0] input_reg_i,
  input  logic [15:0] operation_i,
  output logic [15:0] alu_x_o,
  output logic [15:0] alu_y_o,
  output logic [15:0] alu_ans_o,
  output logic [15:0] out_reg_o
);

  localparam logic [3:0] AddrIn  = 4'hA;
  localparam logic [3:0] AddrX   = 4'hB;
  localparam logic [3:0] AddrY   = 4'hC;
  localparam logic [3:0] AddrAns = 4'hD;
  localparam logic [3:0] AddrOut = 4'hE;

  logic [15:0] gp_q [10];
  logic [15:0] gp_d [10];
  logic [15:0] x_q, x_d;
  logic [15:0] y_q, y_d;
  logic [15:0] out_q, out_d;
  logic [15:0] alu_ans;
  logic [15:0] src;

  // Only operation[2:0] is decoded.
  logic unused_op;
  assign unused_op = ^operation_i[15:3];

  always_comb begin
    alu_ans = '0;
    unique case (operation_i[2:0])
      3'd0: alu_ans = x_q + y_q;
      3'd1: alu_ans = x_q - y_q;
      3'd2: alu_ans = x_q & y_q;
      3'd3: alu_ans = x_q | y_q;
      3'd4: alu_ans = x_q ^ y_q;
      3'd5: alu_ans = ~x_q;
      3'd6: alu_ans = {x_q[14:0], 1'b0};
      3'd7: alu_ans = {1'b0, x_q[15:1]};
      default: alu_ans = '0;
    endcase
  end

  always_comb begin
    src = '0;
    for (int i = 0; i < 10; i++) begin
      if (from_addr_i == 4'(i)) src = gp_q[i];
    end
    case (from_addr_i)
      AddrIn:  src = input_reg_i;
      AddrX:   src = x_q;
      AddrY:   src = y_q;
      AddrAns: src = alu_ans;
      AddrOut: src = out_q;
      default: ;
    endcase
  end

  // Destinations 0xA, 0xD and 0xF match nothing below, so such writes are dropped.
  always_comb begin
    gp_d  = gp_q;
    x_d   = x_q;
    y_d   = y_q;
    out_d = out_q;
    if (enable_i) begin
      for (int i = 0; i < 10; i++) begin
        if (to_addr_i == 4'(i)) gp_d[i] = src;
      end
      if (to_addr_i == AddrX)   x_d   = src;
      if (to_addr_i == AddrY)   y_d   = src;
      if (to_addr_i == AddrOut) out_d = src;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 10; i++) gp_q[i] <= '0;
      x_q   <= '0;
      y_q   <= '0;
      out_q <= '0;
    end else begin
      for (int i = 0; i < 10; i++) gp_q[i] <= gp_d[i];
      x_q   <= x_d;
      y_q   <= y_d;
      out_q <= out_d;
    end
  end

  assign alu_x_o   = x_q;
  assign alu_y_o   = y_q;
  assign alu_ans_o = alu_ans;
  assign out_reg_o = out_q;

endmodule

// File: tb/tb_reg_bank_alu.sv
// Bench for reg_bank_alu: directed scenarios plus random transfers against an address-map model.
module tb_reg_bank_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  from_addr, to_addr;
  logic        enable;
  logic [15:0] input_reg, operation;
  logic [15:0] alu_x, alu_y, alu_ans, out_reg;

  int n_vec = 0;
  int n_err = 0;

  // Model: one word per address; 0xA, 0xD and 0xF are never stored.
  logic [15:0] mem [16];
  logic [15:0] pend;

  reg_bank_alu dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .from_addr_i (from_addr),
    .to_addr_i   (to_addr),
    .enable_i    (enable),
    .input_reg_i (input_reg),
    .operation_i (operation),
    .alu_x_o     (alu_x),
    .alu_y_o     (alu_y),
    .alu_ans_o   (alu_ans),
    .out_reg_o   (out_reg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] m_alu(input logic [15:0] op);
    int unsigned x, y;
    x = mem[11];
    y = mem[12];
    case (op % 8)
      0: return 16'((x + y) % 65536);
      1: return 16'((x + 65536 - y) % 65536);
      2: return mem[11] & mem[12];
      3: return mem[11] | mem[12];
      4: return mem[11] ^ mem[12];
      5: return 16'(65535 - x);
      6: return 16'((x * 2) % 65536);
      default: return 16'(x / 2);
    endcase
  endfunction

  function automatic logic [15:0] m_read(input logic [3:0] a);
    if (a == 4'hA) return input_reg;
    if (a == 4'hD) return m_alu(operation);
    if (a == 4'hF) return 16'h0;
    return mem[a];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) mem[i] = '0;
  endtask

  task automatic check_outs(input string tag);
    check({tag, ".x"},   alu_x,   mem[11]);
    check({tag, ".y"},   alu_y,   mem[12]);
    check({tag, ".out"}, out_reg, mem[14]);
    check({tag, ".ans"}, alu_ans, m_alu(operation));
  endtask

  task automatic step(input logic [3:0] f, input logic [3:0] t, input logic en,
                      input logic [15:0] in, input logic [15:0] op, input bit chk);
    @(negedge clk);
    from_addr = f;
    to_addr   = t;
    enable    = en;
    input_reg = in;
    operation = op;
    #1;
    if (chk) check("ans_pre", alu_ans, m_alu(op));
    pend = m_read(f);
    @(posedge clk);
    if (en && t != 4'hA && t != 4'hD && t != 4'hF) mem[t] = pend;
    #1;
    if (chk) check_outs("step");
  endtask

  initial begin
    rst_n = 1'b0;
    from_addr = '0; to_addr = '0; enable = 1'b0; input_reg = '0; operation = '0;
    m_reset();
    #12;
    check_outs("reset");
    operation = 16'd5;
    #1;
    check("reset.ans_op5", alu_ans, 16'hFFFF);
    operation = 16'd0;
    @(negedge clk);
    rst_n = 1'b1;

    // Load operands then accumulate.
    step(4'hA, 4'hB, 1, 16'd1, 16'd0, 1);
    step(4'hA, 4'hC, 1, 16'd1, 16'd0, 1);
    check("load.ans", alu_ans, 16'd2);
    for (int i = 0; i < 10; i++) step(4'hD, 4'hC, 1, 16'd0, 16'd0, 1);
    check("acc.y", alu_y, 16'd11);
    check("acc.ans", alu_ans, 16'd12);
    for (int i = 0; i < 65535; i++) step(4'hD, 4'hC, 1, 16'd0, 16'd0, 0);
    check_outs("wrap");
    check("wrap.y", alu_y, 16'd10);

    // General register path and hold.
    step(4'hA, 4'h3, 1, 16'h1234, 16'd0, 1);
    step(4'h3, 4'hE, 1, 16'h0, 16'd0, 1);
    check("gp.out", out_reg, 16'h1234);
    for (int i = 0; i < 5; i++) step(4'hA, 4'hB, 0, 16'hBEEF, 16'd0, 1);

    // Read-only destinations.
    step(4'hA, 4'hB, 1, 16'd5, 16'd0, 1);
    step(4'hB, 4'hD, 1, 16'd0, 16'd0, 1);
    step(4'hB, 4'hA, 1, 16'd0, 16'd0, 1);
    step(4'hB, 4'hF, 1, 16'd0, 16'd0, 1);
    check("ro.x", alu_x, 16'd5);
    step(4'hF, 4'hB, 1, 16'd0, 16'd0, 1);
    check("f2b.x", alu_x, 16'd0);

    // ALU ops.
    step(4'hA, 4'hC, 1, 16'd1, 16'd1, 1);
    check("op1", alu_ans, 16'hFFFF);
    step(4'hA, 4'hB, 1, 16'h8001, 16'd6, 1);
    check("op6", alu_ans, 16'h0002);
    step(4'h0, 4'h0, 0, 16'd0, 16'd7, 1);
    check("op7", alu_ans, 16'h4000);
    step(4'h0, 4'h0, 0, 16'd0, 16'hFFF5, 1);
    check("op5", alu_ans, 16'h7FFE);

    // Random transfers, biased so operands and general registers get exercised.
    for (int i = 0; i < 400; i++)
      step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), ($urandom_range(0, 7) != 0),
           16'($urandom), 16'($urandom), 1);
    for (int r = 0; r < 10; r++) begin
      step(4'(r), 4'hE, 1, 16'd0, 16'd0, 1);
      check("gp_dump", out_reg, mem[r]);
    end

    // Mid-run asynchronous reset, away from any edge.
    @(negedge clk);
    operation = 16'd0;
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    check_outs("midreset");
    check("midreset.ans", alu_ans, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'h5, 4'hE, 1, 16'd0, 16'd0, 1);
    check("midreset.gp", out_reg, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
